// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared constants for the instruction fetch stage
package if_fetch_stage_pkg;

    localparam int PC_SIZE_DEFAULT   = 32;
    localparam int INST_SIZE_DEFAULT = 32;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_JR     = 2'b11;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - control, loader and IF/ID signals of the fetch stage (IF_FETCH_COUNT_EN adds o_fetch_count)
interface if_fetch_stage_if #(
   parameter int PC_SIZE   = 32,
   parameter int INST_SIZE = 32,
   parameter int ADDR_W    = 8
);
   logic                 i_pipe_en;
   logic                 i_stall;
   logic [1:0]           i_pc_src;
   logic [PC_SIZE-1:0]   i_branch_addr;
   logic [PC_SIZE-1:0]   i_jump_addr;
   logic [PC_SIZE-1:0]   i_jr_addr;
   logic                 i_wr_en;
   logic [7:0]           i_wr_byte;
   logic                 i_wr_clear;
   logic [INST_SIZE-1:0] o_instr;
   logic [PC_SIZE-1:0]   o_next_pc;
   logic [PC_SIZE-1:0]   o_pc;
   logic                 o_halt;
   logic                 o_mem_full;
   logic [ADDR_W:0]      o_words_loaded;
`ifdef IF_FETCH_COUNT_EN
   logic [31:0]          o_fetch_count;
`endif

   modport master (
`ifdef IF_FETCH_COUNT_EN
      input  o_fetch_count,
`endif
      output i_pipe_en, i_stall, i_pc_src, i_branch_addr, i_jump_addr, i_jr_addr,
             i_wr_en, i_wr_byte, i_wr_clear,
      input  o_instr, o_next_pc, o_pc, o_halt, o_mem_full, o_words_loaded
   );

   modport slave (
`ifdef IF_FETCH_COUNT_EN
      output o_fetch_count,
`endif
      input  i_pipe_en, i_stall, i_pc_src, i_branch_addr, i_jump_addr, i_jr_addr,
             i_wr_en, i_wr_byte, i_wr_clear,
      output o_instr, o_next_pc, o_pc, o_halt, o_mem_full, o_words_loaded
   );
endinterface

// File: rtl/if_fetch_stage_instr_mem_loader.sv
// rtl/if_fetch_stage_instr_mem_loader.sv - instruction memory with big-endian byte loader
module if_fetch_stage_instr_mem_loader #(
   parameter int INST_SIZE = 32,
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_pipe_en,
   input  logic                 i_wr_en,
   input  logic [7:0]           i_wr_byte,
   input  logic                 i_wr_clear,
   input  logic [ADDR_W-1:0]    i_rd_addr,
   output logic [INST_SIZE-1:0] o_rd_data,
   output logic                 o_mem_full,
   output logic [ADDR_W:0]      o_words_loaded
);
   localparam int                 BYTES     = INST_SIZE / 8;
   localparam int                 CNT_W     = $clog2(BYTES);
   localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(BYTES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W:0]    WORD_ONE  = (ADDR_W + 1)'(1);

   logic [INST_SIZE-1:0] mem [MEM_DEPTH];
   logic [INST_SIZE-9:0] asm_q;
   logic [CNT_W-1:0]     byte_cnt;
   logic [ADDR_W:0]      words_q;
   logic                 byte_ok;
   logic                 word_done;

   // words_q doubles as the write pointer; its MSB alone means MEM_DEPTH reached
   assign o_mem_full     = words_q[ADDR_W];
   assign o_words_loaded = words_q;
   assign o_rd_data      = mem[i_rd_addr];

   assign byte_ok   = !i_wr_clear && !i_pipe_en && i_wr_en && !o_mem_full;
   assign word_done = byte_ok && (byte_cnt == LAST_BYTE);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         asm_q    <= '0;
         byte_cnt <= '0;
         words_q  <= '0;
      end else if (i_wr_clear) begin
         byte_cnt <= '0;
         words_q  <= '0;
      end else if (word_done) begin
         byte_cnt <= '0;
         words_q  <= words_q + WORD_ONE;
      end else if (byte_ok) begin
         asm_q    <= {asm_q[INST_SIZE-17:0], i_wr_byte};
         byte_cnt <= byte_cnt + CNT_ONE;
      end
   end

   // Contents survive reset so a program can be rerun without reloading
   always_ff @(posedge i_clock) begin
      if (word_done) begin
         mem[words_q[ADDR_W-1:0]] <= {asm_q, i_wr_byte};
      end
   end
endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC register, next-PC select and HALT detection (IF_FETCH_COUNT_EN adds fetch counter)
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int PC_SIZE   = PC_SIZE_DEFAULT,
   parameter int INST_SIZE = INST_SIZE_DEFAULT,
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic           i_clock,
   input  logic           i_reset,
   if_fetch_stage_if.slave fetch_bus
);
   logic [PC_SIZE-1:0]   pc;
   logic [PC_SIZE-1:0]   pc_sel;
   logic [PC_SIZE-1:0]   pc_plus4;
   logic [INST_SIZE-1:0] instr;
   logic                 halt;
   logic                 advance;
   logic                 halt_hit;

   if_fetch_stage_instr_mem_loader #(
      .INST_SIZE (INST_SIZE),
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_loader (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_pipe_en      (fetch_bus.i_pipe_en),
      .i_wr_en        (fetch_bus.i_wr_en),
      .i_wr_byte      (fetch_bus.i_wr_byte),
      .i_wr_clear     (fetch_bus.i_wr_clear),
      .i_rd_addr      (pc[ADDR_W+1:2]),
      .o_rd_data      (instr),
      .o_mem_full     (fetch_bus.o_mem_full),
      .o_words_loaded (fetch_bus.o_words_loaded)
   );

   assign pc_plus4            = pc + PC_SIZE'(4);
   assign fetch_bus.o_instr   = instr;
   assign fetch_bus.o_next_pc = pc_plus4;
   assign fetch_bus.o_pc      = pc;
   assign fetch_bus.o_halt    = halt;

   assign advance  = fetch_bus.i_pipe_en && !fetch_bus.i_stall && !halt;
   // Only a HALT on the sequential path counts; a redirect makes it wrong-path
   assign halt_hit = advance && (fetch_bus.i_pc_src == PC_SRC_SEQ) &&
                     (instr == INST_SIZE'(HALT_INSTR));

   always_comb begin
      pc_sel = pc_plus4;
      case (fetch_bus.i_pc_src)
         PC_SRC_BRANCH: pc_sel = fetch_bus.i_branch_addr;
         PC_SRC_JUMP:   pc_sel = fetch_bus.i_jump_addr;
         PC_SRC_JR:     pc_sel = fetch_bus.i_jr_addr;
         default:       pc_sel = pc_plus4;
      endcase
   end

   // PC stays on the HALT word so o_instr keeps presenting it
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         pc   <= '0;
         halt <= 1'b0;
      end else if (halt_hit) begin
         halt <= 1'b1;
      end else if (advance) begin
         pc <= pc_sel;
      end
   end

`ifdef IF_FETCH_COUNT_EN
   logic [31:0] fetch_count;

   assign fetch_bus.o_fetch_count = fetch_count;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         fetch_count <= '0;
      end else if (advance && (fetch_count != '1)) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage
module tb_if_fetch_stage;
   localparam int          DEPTH = 256;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [31:0] m_mem [DEPTH];
   bit          m_valid [DEPTH];
   int          m_words;
   int          m_bcnt;
   logic [31:0] m_asm;
   logic [31:0] m_pc;
   bit          m_halt;

   if_fetch_stage_if #(.PC_SIZE(32), .INST_SIZE(32), .ADDR_W(8)) fetch_bus ();

   if_fetch_stage #(.PC_SIZE(32), .INST_SIZE(32), .MEM_DEPTH(DEPTH), .ADDR_W(8)) dut (
      .i_clock   (clk),
      .i_reset   (rst_n),
      .fetch_bus (fetch_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, got no $finish, required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int idx;
      idx = int'(m_pc[9:2]);
      check({tag, ".pc"},      64'(fetch_bus.o_pc), 64'(m_pc));
      check({tag, ".next_pc"}, 64'(fetch_bus.o_next_pc), 64'(m_pc + 32'd4));
      check({tag, ".halt"},    64'(fetch_bus.o_halt), 64'(m_halt));
      check({tag, ".words"},   64'(fetch_bus.o_words_loaded), 64'(m_words));
      check({tag, ".full"},    64'(fetch_bus.o_mem_full), 64'(m_words == DEPTH));
      if (m_valid[idx]) check({tag, ".instr"}, 64'(fetch_bus.o_instr), 64'(m_mem[idx]));
   endtask

   task automatic set_idle();
      fetch_bus.i_pipe_en     = 1'b0;
      fetch_bus.i_stall       = 1'b0;
      fetch_bus.i_pc_src      = 2'b00;
      fetch_bus.i_branch_addr = '0;
      fetch_bus.i_jump_addr   = '0;
      fetch_bus.i_jr_addr     = '0;
      fetch_bus.i_wr_en       = 1'b0;
      fetch_bus.i_wr_byte     = '0;
      fetch_bus.i_wr_clear    = 1'b0;
   endtask

   // One rising edge; the reference model advances from the inputs held across it
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      if (fetch_bus.i_wr_clear) begin
         m_words = 0;
         m_bcnt  = 0;
      end else if (!fetch_bus.i_pipe_en && fetch_bus.i_wr_en && m_words < DEPTH) begin
         m_asm  = {m_asm[23:0], fetch_bus.i_wr_byte};
         m_bcnt = m_bcnt + 1;
         if (m_bcnt == 4) begin
            m_mem[m_words]   = m_asm;
            m_valid[m_words] = 1'b1;
            m_words = m_words + 1;
            m_bcnt  = 0;
         end
      end
      if (fetch_bus.i_pipe_en && !fetch_bus.i_stall && !m_halt) begin
         if (fetch_bus.i_pc_src == 2'b00 && m_valid[m_pc[9:2]] && m_mem[m_pc[9:2]] == HALT)
            m_halt = 1'b1;
         else
            case (fetch_bus.i_pc_src)
               2'b00:   m_pc = m_pc + 32'd4;
               2'b01:   m_pc = fetch_bus.i_branch_addr;
               2'b10:   m_pc = fetch_bus.i_jump_addr;
               default: m_pc = fetch_bus.i_jr_addr;
            endcase
      end
      check_model(tag);
   endtask

   task automatic send_byte(input logic [7:0] b);
      fetch_bus.i_wr_en   = 1'b1;
      fetch_bus.i_wr_byte = b;
      tick("load");
      fetch_bus.i_wr_en   = 1'b0;
   endtask

   // Reset asserted between edges; outputs must clear without a clock
   task automatic do_reset(input string tag);
      set_idle();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      m_pc = '0; m_halt = 1'b0; m_words = 0; m_bcnt = 0;
      check_model(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0]  prog [12];
      logic [31:0] w;
      logic [31:0] stall_instr;
      n_checks = 0; n_errors = 0;
      m_words = 0; m_bcnt = 0; m_asm = '0; m_pc = '0; m_halt = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_mem[i] = '0; end
      prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
      set_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) send_byte(prog[i]);
      check("load3.words", 64'(fetch_bus.o_words_loaded), 64'd3);

      fetch_bus.i_pipe_en = 1'b1;
      check("seq.instr0", 64'(fetch_bus.o_instr), 64'h2001_0005);
      tick("seq1");
      check("seq.pc4", 64'(fetch_bus.o_pc), 64'd4);
      tick("seq2");
      check("seq.pc8", 64'(fetch_bus.o_pc), 64'd8);
      check("seq.instr_halt", 64'(fetch_bus.o_instr), 64'(HALT));
      check("seq.halt_low", 64'(fetch_bus.o_halt), 64'd0);
      tick("seq3");
      check("seq.halt_rise", 64'(fetch_bus.o_halt), 64'd1);
      repeat (3) tick("seq_hold");
      check("seq.pc_frozen", 64'(fetch_bus.o_pc), 64'd8);

      do_reset("reset_after_halt");
      fetch_bus.i_pipe_en = 1'b1;
      tick("redir_a");
      tick("redir_b");
      fetch_bus.i_pc_src      = 2'b01;
      fetch_bus.i_branch_addr = 32'd0;
      tick("redir");
      check("redir.no_halt", 64'(fetch_bus.o_halt), 64'd0);
      check("redir.pc0", 64'(fetch_bus.o_pc), 64'd0);
      fetch_bus.i_pc_src = 2'b00;

      tick("stall_pre");
      stall_instr = fetch_bus.o_instr;
      fetch_bus.i_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick("stall");
         check("stall.pc", 64'(fetch_bus.o_pc), 64'd4);
         check("stall.instr", 64'(fetch_bus.o_instr), 64'(stall_instr));
      end
      fetch_bus.i_stall = 1'b0;
      tick("stall_release");
      check("stall.pc8", 64'(fetch_bus.o_pc), 64'd8);

      fetch_bus.i_pipe_en = 1'b0;
      for (int i = 0; i < 4 * DEPTH + 4; i++) send_byte(8'($urandom));
      check("full.flag", 64'(fetch_bus.o_mem_full), 64'd1);
      check("full.words", 64'(fetch_bus.o_words_loaded), 64'(DEPTH));
      fetch_bus.i_wr_clear = 1'b1;
      fetch_bus.i_wr_en    = 1'b1;
      fetch_bus.i_wr_byte  = 8'hA5;
      tick("clear");
      set_idle();
      check("clear.words", 64'(fetch_bus.o_words_loaded), 64'd0);
      check("clear.full", 64'(fetch_bus.o_mem_full), 64'd0);
      w = $urandom;
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
      check("clear.words1", 64'(fetch_bus.o_words_loaded), 64'd1);
      fetch_bus.i_pipe_en   = 1'b1;
      fetch_bus.i_pc_src    = 2'b10;
      fetch_bus.i_jump_addr = 32'd0;
      tick("jump0");
      check("clear.word0", 64'(fetch_bus.o_instr), 64'(w));
      fetch_bus.i_jump_addr = 32'd1020;
      tick("jump_last");

      for (int c = 0; c < 600; c++) begin
         if (c % 150 == 149) do_reset("rand_reset");
         fetch_bus.i_pipe_en     = ($urandom_range(0, 7) != 0);
         fetch_bus.i_stall       = ($urandom_range(0, 4) == 0);
         fetch_bus.i_pc_src      = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         fetch_bus.i_branch_addr = $urandom;
         fetch_bus.i_jump_addr   = $urandom;
         fetch_bus.i_jr_addr     = $urandom;
         fetch_bus.i_wr_en       = 1'($urandom);
         fetch_bus.i_wr_byte     = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         tick("rand");
      end

      set_idle();
      fetch_bus.i_pipe_en   = 1'b1;
      fetch_bus.i_pc_src    = 2'b10;
      fetch_bus.i_jump_addr = 32'd12;
      tick("to12");
      check("areset.pc12", 64'(fetch_bus.o_pc), 64'd12);
      do_reset("areset");
      check("areset.mem0", 64'(fetch_bus.o_instr), 64'(m_mem[0]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
